// File: rtl/nn_disp_pkg.sv
// rtl/nn_disp_pkg.sv - shared FSM encoding, display modes and 7-segment codes
package nn_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LATEST  = 2'd0;
  localparam logic [1:0] MODE_HISTORY = 2'd1;
  localparam logic [1:0] MODE_COUNT   = 2'd2;
  localparam logic [1:0] MODE_OFF     = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low gfedcba patterns, hex digits A-F included
  function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
    case (nibble)
      4'h0:    seg7_hex = 7'h40;
      4'h1:    seg7_hex = 7'h79;
      4'h2:    seg7_hex = 7'h24;
      4'h3:    seg7_hex = 7'h30;
      4'h4:    seg7_hex = 7'h19;
      4'h5:    seg7_hex = 7'h12;
      4'h6:    seg7_hex = 7'h02;
      4'h7:    seg7_hex = 7'h78;
      4'h8:    seg7_hex = 7'h00;
      4'h9:    seg7_hex = 7'h10;
      4'hA:    seg7_hex = 7'h08;
      4'hB:    seg7_hex = 7'h03;
      4'hC:    seg7_hex = 7'h46;
      4'hD:    seg7_hex = 7'h21;
      4'hE:    seg7_hex = 7'h06;
      default: seg7_hex = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/nn_key_debounce.sv
// rtl/nn_key_debounce.sv - key synchroniser, stable counter and one-cycle press pulse
module nn_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic [DB_W-1:0] cnt;

  // level flips on the DEBOUNCE_CYCLES-th consecutive sample that differs from it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync2;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nn_run_display_ctrl.sv
// rtl/nn_run_display_ctrl.sv - start/done handshake with timeout, result history and 7-seg display
module nn_run_display_ctrl
  import nn_disp_pkg::*;
#(
  parameter int NUM_CLASSES     = 10,
  parameter int CLASS_W         = 4,
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    key_start_n,
  input  logic [1:0]              mode,
  input  logic                    nn_done,
  input  logic [CLASS_W-1:0]      nn_class,
  output logic                    nn_start,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [15:0]             run_count,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  state_t                 state;
  state_t                 state_next;
  logic                   press;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   tmo_hit;
  logic                   done_acc;
  logic                   tmo_acc;
  logic                   class_inv;
  logic                   hist_valid [NUM_DIGITS];
  logic                   hist_inv   [NUM_DIGITS];
  logic [CLASS_W-1:0]     hist_class [NUM_DIGITS];
  logic [6:0]             entry_seg  [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] hex_next;

  nn_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .resetn(resetn),
    .key_n (key_start_n),
    .press (press)
  );

  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign done_acc  = (state == ST_WAIT) && nn_done;
  assign tmo_acc   = (state == ST_WAIT) && !nn_done && tmo_hit;
  assign class_inv = {1'b0, nn_class} >= (CLASS_W + 1)'(NUM_CLASSES);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // done is tested before the timeout limit so a late result still counts
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (press) state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (done_acc || tmo_acc) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    nn_start = (state == ST_START);
    busy     = (state == ST_START) || (state == ST_WAIT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
      run_count   <= '0;
      hex_out     <= '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hist_valid[i] <= 1'b0;
        hist_inv[i]   <= 1'b0;
        hist_class[i] <= '0;
      end
    end else begin
      hex_out <= hex_next;
      if (state == ST_START)     tmo_cnt <= '0;
      else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      if ((state == ST_IDLE) && press) timeout_err <= 1'b0;
      else if (tmo_acc)                timeout_err <= 1'b1;
      if (done_acc) begin
        run_count <= run_count + 16'd1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
          hist_valid[i] <= hist_valid[i-1];
          hist_inv[i]   <= hist_inv[i-1];
          hist_class[i] <= hist_class[i-1];
        end
        hist_valid[0] <= 1'b1;
        hist_inv[0]   <= class_inv;
        hist_class[0] <= nn_class;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!hist_valid[i])  entry_seg[i] = SEG_BLANK;
      else if (hist_inv[i]) entry_seg[i] = SEG_DASH;
      else                 entry_seg[i] = seg7_hex(4'(hist_class[i]));
    end
  end

  always_comb begin
    hex_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      case (mode)
        MODE_LATEST:  if (i == 0) hex_next[7*i +: 7] = entry_seg[0];
        MODE_HISTORY: hex_next[7*i +: 7] = entry_seg[i];
        MODE_COUNT:   if (i < 4) hex_next[7*i +: 7] = seg7_hex(4'(run_count >> (4*i)));
        default:      hex_next[7*i +: 7] = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_run_display_ctrl.sv
// tb/tb_nn_run_display_ctrl.sv - scoreboard bench for nn_run_display_ctrl
module tb_nn_run_display_ctrl;

  localparam int NUM_CLASSES = 10;
  localparam int CLASS_W     = 4;
  localparam int NUM_DIGITS  = 4;
  localparam int DEB         = 16;
  localparam int TMO         = 4096;

  logic                    clk = 1'b0;
  logic                    resetn = 1'b0;
  logic                    key_start_n = 1'b1;
  logic [1:0]              mode = 2'd0;
  logic                    nn_done = 1'b0;
  logic [CLASS_W-1:0]      nn_class = '0;
  logic                    nn_start;
  logic                    busy;
  logic                    timeout_err;
  logic [15:0]             run_count;
  logic [7*NUM_DIGITS-1:0] hex_out;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0]              mdl_hist [NUM_DIGITS];
  logic [15:0]             mdl_count;
  logic [7*NUM_DIGITS-1:0] exp_q [$];

  int   start_pulses = 0;
  int   wide_pulses  = 0;
  logic prev_start   = 1'b0;

  always #5 clk = ~clk;

  nn_run_display_ctrl #(
    .NUM_CLASSES    (NUM_CLASSES),
    .CLASS_W        (CLASS_W),
    .NUM_DIGITS     (NUM_DIGITS),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .key_start_n(key_start_n),
    .mode       (mode),
    .nn_done    (nn_done),
    .nn_class   (nn_class),
    .nn_start   (nn_start),
    .busy       (busy),
    .timeout_err(timeout_err),
    .run_count  (run_count),
    .hex_out    (hex_out)
  );

  always @(negedge clk) begin
    if (nn_start) start_pulses++;
    if (nn_start && prev_start) wide_pulses++;
    prev_start = nn_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < NUM_DIGITS; i++) mdl_hist[i] = 7'h7F;
    mdl_count = 16'd0;
    exp_q.delete();
  endtask

  task automatic mdl_push(input int c);
    for (int i = NUM_DIGITS - 1; i > 0; i--) mdl_hist[i] = mdl_hist[i-1];
    mdl_hist[0] = (c >= NUM_CLASSES) ? 7'h3F : seg_tab[c];
    mdl_count = mdl_count + 16'd1;
  endtask

  function automatic logic [7*NUM_DIGITS-1:0] exp_hex();
    logic [7*NUM_DIGITS-1:0] h;
    h = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      case (mode)
        2'd0: if (i == 0) h[6:0] = mdl_hist[0];
        2'd1: h[7*i +: 7] = mdl_hist[i];
        2'd2: if (i < 4) h[7*i +: 7] = seg_tab[4'(mdl_count >> (4*i))];
        default: ;
      endcase
    end
    return h;
  endfunction

  task automatic apply_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    mdl_clear();
  endtask

  task automatic do_press(output bit ok);
    ok = 1'b0;
    key_start_n = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (nn_start) ok = 1'b1;
    end
    key_start_n = 1'b1;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL press_start: nn_start=0 within 40 cycles, required 1");
    end
  endtask

  task automatic finish_run(input int c, input int dly);
    logic [7*NUM_DIGITS-1:0] e;
    repeat (dly) tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_wait: got %b want 1", busy);
    end
    nn_class = CLASS_W'(c);
    nn_done  = 1'b1;
    mdl_push(c);
    exp_q.push_back(exp_hex());
    tick();
    nn_done = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_after_done: got %b want 0", busy);
    end
    total++;
    if (run_count !== mdl_count) begin
      bad++;
      $display("FAIL run_count class=%0d: got %0d want %0d", c, run_count, mdl_count);
    end
    tick();
    e = exp_q.pop_front();
    total++;
    if (hex_out !== e) begin
      bad++;
      $display("FAIL hex_after_run class=%0d: got %h want %h", c, hex_out, e);
    end
  endtask

  task automatic do_run(input int c, input int dly);
    bit ok;
    do_press(ok);
    finish_run(c, dly);
  endtask

  task automatic check_display(input string name);
    logic [7*NUM_DIGITS-1:0] e;
    exp_q.push_back(exp_hex());
    tick();
    e = exp_q.pop_front();
    total++;
    if (hex_out !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, hex_out, e);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    total++;
    if (hex_out !== {(7*NUM_DIGITS){1'b1}}) begin
      bad++;
      $display("FAIL reset_hex: got %h want all ones", hex_out);
    end
    total++;
    if ({nn_start, busy, timeout_err} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl: got start/busy/tmo=%b want 000", {nn_start, busy, timeout_err});
    end
    total++;
    if (run_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_count: got %0d want 0", run_count);
    end
    resetn = 1'b1;
    tick();
    mdl_clear();
  endtask

  task automatic test_bounce();
    int s0;
    int w0;
    s0 = start_pulses;
    w0 = wide_pulses;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) key_start_n = ~key_start_n;
      tick();
    end
    key_start_n = 1'b0;
    repeat (20) tick();
    key_start_n = 1'b1;
    repeat (10) tick();
    total++;
    if (start_pulses - s0 !== 1) begin
      bad++;
      $display("FAIL bounce_pulses: got %0d want 1", start_pulses - s0);
    end
    total++;
    if (wide_pulses !== w0) begin
      bad++;
      $display("FAIL bounce_width: got %0d wide pulses want 0", wide_pulses - w0);
    end
    apply_reset();
  endtask

  task automatic test_run();
    mode = 2'd0;
    do_run(7, 100);
  endtask

  task automatic test_history();
    mode = 2'd1;
    for (int c = 1; c <= 5; c++) do_run(c, 25);
    check_display("history_digits");
  endtask

  task automatic test_modes();
    mode = 2'd2;
    check_display("mode_count");
    mode = 2'd3;
    check_display("mode_off");
    mode = 2'd0;
    check_display("mode_latest");
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    mode = 2'd0;
    do_press(ok);
    n = 0;
    while (busy && n < TMO + 100) begin
      tick();
      n++;
    end
    total++;
    if (n < TMO - 1 || n > TMO + 2) begin
      bad++;
      $display("FAIL timeout_len: busy for %0d cycles want about %0d", n, TMO);
    end
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_flag: got %b want 1", timeout_err);
    end
    total++;
    if (run_count !== mdl_count) begin
      bad++;
      $display("FAIL timeout_count: got %0d want %0d", run_count, mdl_count);
    end
    check_display("timeout_hex_kept");
    do_press(ok);
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: got %b want 0", timeout_err);
    end
    finish_run(12, 30);
  endtask

  task automatic test_edge();
    bit ok;
    int s0;
    mode = 2'd1;
    nn_class = 4'd3;
    nn_done  = 1'b1;
    repeat (3) tick();
    nn_done = 1'b0;
    total++;
    if (run_count !== mdl_count) begin
      bad++;
      $display("FAIL done_in_idle: got %0d want %0d", run_count, mdl_count);
    end
    check_display("done_in_idle_hex");
    s0 = start_pulses;
    do_press(ok);
    repeat (25) tick();
    key_start_n = 1'b0;
    repeat (25) tick();
    key_start_n = 1'b1;
    repeat (25) tick();
    total++;
    if (start_pulses - s0 !== 1) begin
      bad++;
      $display("FAIL press_in_wait: got %0d starts want 1", start_pulses - s0);
    end
    resetn = 1'b0;
    #1;
    total++;
    if ({nn_start, busy} !== 2'b00) begin
      bad++;
      $display("FAIL async_reset: got start/busy=%b want 00", {nn_start, busy});
    end
    tick();
    resetn = 1'b1;
    tick();
    mdl_clear();
    total++;
    if (hex_out !== {(7*NUM_DIGITS){1'b1}} || run_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_in_wait: got hex=%h count=%0d want all ones and 0", hex_out, run_count);
    end
    mode = 2'd0;
    do_run(9, 30);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_run();
    test_history();
    test_modes();
    test_timeout();
    test_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
